// File: rtl/input_port_buffer_if.sv
// Flit handshake bundle between an upstream link, the input port buffer and the transport stage.
// The slave side is the buffer; the master side is whatever drives flits in and pops them out.
interface input_port_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_flit;
  logic        out_valid;
  logic [39:0] out_flit;
  logic [1:0]  route_out;
  logic        out_pop;

  modport master (
    output in_valid, in_flit, out_pop,
    input  in_ready, out_valid, out_flit, route_out
  );

  modport slave (
    input  in_valid, in_flit, out_pop,
    output in_ready, out_valid, out_flit, route_out
  );
endinterface

// File: rtl/input_port_buffer.sv
// Per-port flit FIFO with a one-entry output stage carrying the registered XY route of its flit.
// Flits with out-of-mesh destinations are discarded at stage load and counted.
module input_port_buffer #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0,
  parameter int MESH_X  = 4,
  parameter int MESH_Y  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input_port_buffer_if.slave   port,
  output logic                 err_drop,
  output logic [7:0]           drop_cnt,
  output logic [AW:0]          fifo_count
);

  logic [39:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          push;
  logic          stage_pop;
  logic          stage_free;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          fifo_wr;
  logic          bypass;
  logic          cand_vld;
  logic          cand_legal;
  logic [39:0]   cand;
  logic [1:0]    cand_route;

  // rst_n is the active-high reset here, so ready is held low while it is asserted.
  assign fifo_empty    = (fifo_count == '0);
  assign port.in_ready = !rst_n && (fifo_count < (AW+1)'(DEPTH));
  assign push          = port.in_valid & port.in_ready;
  assign stage_pop     = port.out_pop & port.out_valid;
  assign stage_free    = !port.out_valid | stage_pop;
  assign fifo_wr       = push & !bypass;

  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    if (stage_free) begin
      if (!fifo_empty) begin
        cand     = mem[rd_ptr];
        cand_vld = 1'b1;
        fifo_pop = 1'b1;
      end else if (push) begin
        cand     = port.in_flit;
        cand_vld = 1'b1;
        bypass   = 1'b1;
      end
    end
  end

  always_comb begin
    cand_legal = ({1'b0, cand[39:36]} < 5'(MESH_X)) && ({1'b0, cand[35:32]} < 5'(MESH_Y));
    if (cand[39:36] != 4'(LOCAL_X))
      cand_route = 2'b01;
    else if (cand[35:32] != 4'(LOCAL_Y))
      cand_route = 2'b10;
    else
      cand_route = 2'b11;
  end

  // Storage is not reset; pointers and occupancy alone define the content.
  always_ff @(posedge clk) begin
    if (fifo_wr)
      mem[wr_ptr] <= port.in_flit;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      port.out_valid <= 1'b0;
      port.out_flit  <= '0;
      port.route_out <= 2'b00;
      err_drop       <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      err_drop <= 1'b0;
      if (fifo_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (fifo_wr && !fifo_pop)
        fifo_count <= fifo_count + 1'b1;
      else if (!fifo_wr && fifo_pop)
        fifo_count <= fifo_count - 1'b1;

      if (stage_free) begin
        if (cand_vld && cand_legal) begin
          port.out_valid <= 1'b1;
          port.out_flit  <= cand;
          port.route_out <= cand_route;
        end else begin
          port.out_valid <= 1'b0;
          port.route_out <= 2'b00;
        end
      end

      if (cand_vld && !cand_legal) begin
        err_drop <= 1'b1;
        if (drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_input_port_buffer.sv
// Randomised and directed bench for input_port_buffer against a queue-based reference model.
module tb_input_port_buffer;
  localparam int DEPTH = 4;
  localparam int LX = 0;
  localparam int LY = 0;
  localparam int MX = 4;
  localparam int MY = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       err_drop;
  logic [7:0] drop_cnt;
  logic [2:0] fifo_count;

  input_port_buffer_if ifc ();

  input_port_buffer #(
    .DEPTH(DEPTH), .AW(2), .LOCAL_X(LX), .LOCAL_Y(LY), .MESH_X(MX), .MESH_Y(MY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .port(ifc.slave),
    .err_drop(err_drop), .drop_cnt(drop_cnt), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // reference model: FIFO contents as a queue plus the single output slot
  logic [39:0] mq[$];
  logic        m_ov;
  logic [39:0] m_flit;
  logic [1:0]  m_route;
  logic        m_err;
  int          m_drop;

  function automatic logic [39:0] mk(input int dx, input int dy);
    return {4'(dx), 4'(dy), 32'($urandom)};
  endfunction

  function automatic logic [1:0] ref_route(input logic [39:0] f);
    if (int'(f[39:36]) != LX) return 2'b01;
    if (int'(f[35:32]) != LY) return 2'b10;
    return 2'b11;
  endfunction

  function automatic bit ref_legal(input logic [39:0] f);
    return (int'(f[39:36]) < MX) && (int'(f[35:32]) < MY);
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ov = 0; m_flit = '0; m_route = 2'b00; m_err = 0; m_drop = 0;
  endtask

  task automatic step(input logic v, input logic [39:0] f, input logic p);
    bit acc, free, have;
    logic [39:0] c;
    ifc.in_valid = v; ifc.in_flit = f; ifc.out_pop = p;
    @(posedge clk);
    acc  = v && (mq.size() < DEPTH);
    free = !m_ov || p;
    have = 0;
    c = '0;
    m_err = 0;
    if (free && mq.size() > 0) begin
      c = mq.pop_front(); have = 1;
      if (acc) mq.push_back(f);
    end else if (free && acc) begin
      c = f; have = 1;
    end else if (acc) begin
      mq.push_back(f);
    end
    if (free) begin
      if (have && ref_legal(c)) begin
        m_ov = 1; m_flit = c; m_route = ref_route(c);
      end else begin
        m_ov = 0; m_route = 2'b00;
      end
      if (have && !ref_legal(c)) begin
        m_err = 1;
        if (m_drop < 255) m_drop++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    ifc.in_valid = 0; ifc.in_flit = '0; ifc.out_pop = 0;
    rst_n = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  task automatic test_reset();
    ifc.in_valid = 0; ifc.in_flit = '0; ifc.out_pop = 0;
    rst_n = 1'b1;
    model_clear();
    #2;
    n_checks++; if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", ifc.in_ready); end
    n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ifc.out_valid); end
    n_checks++; if (ifc.out_flit !== 40'h0) begin n_fail++; $display("FAIL reset_out_flit got %h want 0", ifc.out_flit); end
    n_checks++; if (ifc.route_out !== 2'b00) begin n_fail++; $display("FAIL reset_route got %b want 00", ifc.route_out); end
    n_checks++; if (err_drop !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %b/%0d want 0/0", err_drop, drop_cnt); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", ifc.in_ready); end
  endtask

  task automatic test_single();
    logic [39:0] f;
    f = mk(2, 0);
    step(1, f, 0);
    step(0, '0, 0);
    n_checks++; if (ifc.out_valid !== 1'b1 || ifc.route_out !== 2'b01) begin n_fail++; $display("FAIL single_load got v=%b r=%b want v=1 r=01", ifc.out_valid, ifc.route_out); end
    n_checks++; if (ifc.out_flit !== f) begin n_fail++; $display("FAIL single_flit got %h want %h", ifc.out_flit, f); end
    step(0, '0, 1);
    n_checks++; if (ifc.out_valid !== 1'b0 || ifc.route_out !== 2'b00) begin n_fail++; $display("FAIL single_pop got v=%b r=%b want v=0 r=00", ifc.out_valid, ifc.route_out); end
  endtask

  task automatic test_routing();
    int dx[3] = '{0, 0, 3};
    int dy[3] = '{3, 0, 3};
    logic [1:0] want[3] = '{2'b10, 2'b11, 2'b01};
    for (int i = 0; i < 3; i++) begin
      step(1, mk(dx[i], dy[i]), 0);
      n_checks++; if (ifc.out_valid !== 1'b1 || ifc.route_out !== want[i]) begin n_fail++; $display("FAIL route_%0d got v=%b r=%b want v=1 r=%b", i, ifc.out_valid, ifc.route_out, want[i]); end
      step(0, '0, 1);
    end
  endtask

  task automatic test_fill();
    logic [39:0] f[6];
    for (int i = 0; i < 6; i++) begin
      f[i] = mk(i % 4, (i + 1) % 4);
      step(1, f[i], 0);
    end
    n_checks++; if (fifo_count !== 3'd4 || ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got cnt=%0d rdy=%b want 4/0", fifo_count, ifc.in_ready); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (ifc.out_valid !== 1'b1 || ifc.out_flit !== f[i]) begin n_fail++; $display("FAIL fill_order_%0d got v=%b %h want v=1 %h", i, ifc.out_valid, ifc.out_flit, f[i]); end
      step(0, '0, 1);
    end
    n_checks++; if (ifc.out_valid !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL fill_drained got v=%b cnt=%0d want 0/0", ifc.out_valid, fifo_count); end
  endtask

  task automatic test_full_pop_push();
    logic [39:0] f[5];
    logic [39:0] extra;
    for (int i = 0; i < 5; i++) begin
      f[i] = mk(3 - (i % 4), i % 4);
      step(1, f[i], 0);
    end
    extra = mk(1, 1);
    step(1, extra, 1);
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count got %0d want 3", fifo_count); end
    n_checks++; if (ifc.out_flit !== f[1]) begin n_fail++; $display("FAIL full_pop_head got %h want %h", ifc.out_flit, f[1]); end
    for (int i = 1; i < 5; i++) begin
      n_checks++; if (ifc.out_flit !== m_flit || ifc.out_valid !== 1'b1) begin n_fail++; $display("FAIL full_drain_%0d got %h want %h", i, ifc.out_flit, m_flit); end
      step(0, '0, 1);
    end
    n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_no_extra got v=%b want 0", ifc.out_valid); end
  endtask

  task automatic test_random();
    int dx, dy;
    for (int n = 0; n < 400; n++) begin
      dx = $urandom_range(0, 5);
      dy = $urandom_range(0, 5);
      step(1'($urandom_range(0, 3) != 0), mk(dx, dy), 1'($urandom_range(0, 2) != 0));
      n_checks++;
      if (ifc.out_valid !== m_ov || ifc.route_out !== m_route || err_drop !== m_err ||
          drop_cnt !== 8'(m_drop) || fifo_count !== 3'(mq.size()) ||
          ifc.in_ready !== (mq.size() < DEPTH) || (m_ov && ifc.out_flit !== m_flit)) begin
        n_fail++;
        $display("FAIL rand_%0d got v=%b r=%b e=%b d=%0d c=%0d f=%h want v=%b r=%b e=%b d=%0d c=%0d f=%h",
                 n, ifc.out_valid, ifc.route_out, err_drop, drop_cnt, fifo_count, ifc.out_flit,
                 m_ov, m_route, m_err, m_drop, mq.size(), m_flit);
      end
    end
  endtask

  task automatic test_drop();
    step(1, mk(5, 1), 0);
    n_checks++; if (err_drop !== 1'b1 || drop_cnt !== 8'd1 || ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_one got e=%b d=%0d v=%b want 1/1/0", err_drop, drop_cnt, ifc.out_valid); end
    step(0, '0, 0);
    n_checks++; if (err_drop !== 1'b0 || ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_pulse got e=%b v=%b want 0/0", err_drop, ifc.out_valid); end
    for (int i = 0; i < 300; i++)
      step(1, mk(1 + (i % 3), 4 + (i % 2)), 0);
    n_checks++; if (drop_cnt !== 8'd255 || err_drop !== 1'b1) begin n_fail++; $display("FAIL drop_sat got d=%0d e=%b want 255/1", drop_cnt, err_drop); end
    n_checks++; if (m_drop != 255) begin n_fail++; $display("FAIL drop_model got %0d want 255", m_drop); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1, mk(1, 2), 0);
    n_checks++; if (fifo_count !== 3'd2 || ifc.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill got c=%0d v=%b want 2/1", fifo_count, ifc.out_valid); end
    #2 rst_n = 1'b1;
    #1;
    n_checks++; if (ifc.out_valid !== 1'b0 || ifc.out_flit !== 40'h0 || ifc.route_out !== 2'b00 || fifo_count !== 3'd0 || ifc.in_ready !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL mid_reset got v=%b f=%h r=%b c=%0d rdy=%b d=%0d want all zero", ifc.out_valid, ifc.out_flit, ifc.route_out, fifo_count, ifc.in_ready, drop_cnt);
    end
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 1);
      n_checks++; if (ifc.out_valid !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_stale_%0d got v=%b c=%0d want 0/0", i, ifc.out_valid, fifo_count); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_routing();
    test_fill();
    test_full_pop_push();
    test_random();
    do_reset();
    test_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
